// File: rtl/contador_multicanal_if.sv
// contador_multicanal_if: switch/display bundle between the board top and the
// counter bank. The master modport is the board side (drives switches) and the
// slave modport is the counter bank.
interface contador_multicanal_if #(
  parameter int NBITS = 8,
  parameter int NCHAN = 4
);
  localparam int SEL_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic                   en;
  logic [SEL_W-1:0]       chan_sel;
  logic [1:0]             mode;
  logic                   wrap;
  logic [NBITS-1:0]       load_val;
  logic [NBITS-1:0]       count;
  logic [NCHAN*NBITS-1:0] count_all;
  logic [NCHAN-1:0]       tc;
  logic [7:0]             SEG;
  logic [7:0]             LED;

  modport master (
    output en, chan_sel, mode, wrap, load_val,
    input  count, count_all, tc, SEG, LED
  );

  modport slave (
    input  en, chan_sel, mode, wrap, load_val,
    output count, count_all, tc, SEG, LED
  );
endinterface

// File: rtl/contador_multicanal.sv
// contador_multicanal: bank of NCHAN up/down counters sharing one prescaled tick.
// Only the channel addressed by chan_sel is stepped or loaded; the selected
// count drives the 7-segment display and the LEDs.
// Optional build macro CONTADOR_BCD_EN: counters run in packed BCD
// (NBITS a multiple of 4, max = all nines, loaded nibbles above 9 clamp to 9).
module contador_multicanal #(
  parameter int NBITS    = 8,
  parameter int NCHAN    = 4,
  parameter int PRESCALE = 1
) (
  input logic                  clk_2,
  input logic                  reset,
  contador_multicanal_if.slave bus
);

  // The prescaler is kept as a down-counter: PRESCALE-1 remaining cycles right
  // after reset, tick when it reaches zero with en high.
  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_TOP = PW'(PRESCALE - 1);

`ifdef CONTADOR_BCD_EN
  localparam logic [NBITS-1:0] MAXV = {(NBITS / 4){4'h9}};
`else
  localparam logic [NBITS-1:0] MAXV = '1;
`endif

  logic [PW-1:0]    presc;
  logic             tick;
  logic [NBITS-1:0] cnt   [NCHAN];
  logic [NBITS-1:0] cnt_d [NCHAN];
  logic [NCHAN-1:0] tc_q;
  logic [NCHAN-1:0] tc_d;

  logic [NBITS-1:0]       sel_cnt;
  logic                   sel_tc;
  logic [NCHAN*NBITS-1:0] all_cnt;
  logic [3:0]             nib;
  logic [6:0]             seg_g2a;

  function automatic logic [NBITS-1:0] step_up(input logic [NBITS-1:0] v);
`ifdef CONTADOR_BCD_EN
    logic [NBITS-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < NBITS / 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] >= 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
`else
    return v + NBITS'(1);
`endif
  endfunction

  function automatic logic [NBITS-1:0] step_down(input logic [NBITS-1:0] v);
`ifdef CONTADOR_BCD_EN
    logic [NBITS-1:0] r;
    logic             borrow;
    r      = v;
    borrow = 1'b1;
    for (int d = 0; d < NBITS / 4; d++) begin
      if (borrow) begin
        if (r[d*4 +: 4] == 4'd0) begin
          r[d*4 +: 4] = 4'd9;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
`else
    return v - NBITS'(1);
`endif
  endfunction

  // BCD loads are sanitised so the counter never holds a non-decimal digit.
  function automatic logic [NBITS-1:0] load_fix(input logic [NBITS-1:0] v);
`ifdef CONTADOR_BCD_EN
    logic [NBITS-1:0] r;
    r = v;
    for (int d = 0; d < NBITS / 4; d++) begin
      if (r[d*4 +: 4] > 4'd9) r[d*4 +: 4] = 4'd9;
    end
    return r;
`else
    return v;
`endif
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick = bus.en && (presc == '0);

  // Next value for the addressed channel; a step that starts at a bound raises tc.
  always_comb begin
    cnt_d = cnt;
    tc_d  = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (32'(bus.chan_sel) == 32'(i)) begin
        case (bus.mode)
          2'b01: begin
            if (tick) begin
              if (cnt[i] == MAXV) begin
                tc_d[i]  = 1'b1;
                cnt_d[i] = bus.wrap ? '0 : MAXV;
              end else begin
                cnt_d[i] = step_up(cnt[i]);
              end
            end
          end
          2'b10: begin
            if (tick) begin
              if (cnt[i] == '0) begin
                tc_d[i]  = 1'b1;
                cnt_d[i] = bus.wrap ? MAXV : '0;
              end else begin
                cnt_d[i] = step_down(cnt[i]);
              end
            end
          end
          2'b11:   cnt_d[i] = load_fix(bus.load_val);
          default: cnt_d[i] = cnt[i];
        endcase
      end
    end
  end

  // Prescaler, counters and tc register; reset clears everything including a pending tick.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      presc <= PRE_TOP;
      tc_q  <= '0;
      for (int i = 0; i < NCHAN; i++) cnt[i] <= '0;
    end else begin
      if (bus.en) presc <= (presc == '0) ? PRE_TOP : presc - PW'(1);
      tc_q <= tc_d;
      for (int i = 0; i < NCHAN; i++) cnt[i] <= cnt_d[i];
    end
  end

  // Output mux; an out-of-range chan_sel matches no channel and shows zero.
  always_comb begin
    sel_cnt = '0;
    sel_tc  = 1'b0;
    all_cnt = '0;
    for (int i = 0; i < NCHAN; i++) begin
      all_cnt[i*NBITS +: NBITS] = cnt[i];
      if (32'(bus.chan_sel) == 32'(i)) begin
        sel_cnt = cnt[i];
        sel_tc  = tc_q[i];
      end
    end
  end

  // Display decode of the low digit; in BCD builds only 0-9 are shown.
  always_comb begin
    nib     = 4'(sel_cnt);
    seg_g2a = seg7(nib);
`ifdef CONTADOR_BCD_EN
    if (nib > 4'd9) seg_g2a = 7'h00;
`endif
  end

  assign bus.count     = sel_cnt;
  assign bus.count_all = all_cnt;
  assign bus.tc        = tc_q;
  assign bus.SEG       = {sel_tc, seg_g2a};
  assign bus.LED       = 8'(sel_cnt);

endmodule

// File: tb/tb_contador_multicanal.sv
// tb_contador_multicanal: directed bench with a behavioural model; expected
// outputs are queued before each clock edge and compared after it.
module tb_contador_multicanal;
  localparam int NBITS    = 8;
  localparam int NCHAN    = 4;
  localparam int PRESCALE = 2;

`ifdef CONTADOR_BCD_EN
  localparam logic [7:0] MAXV_E    = 8'h99;
  localparam logic [7:0] LOAD_FE_E = 8'h99;
  localparam int         PULSES_E  = 4;
`else
  localparam logic [7:0] MAXV_E    = 8'hFF;
  localparam logic [7:0] LOAD_FE_E = 8'hFE;
  localparam int         PULSES_E  = 3;
`endif

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [31:0] all;
    logic [3:0]  tc;
    logic [7:0]  cnt;
    logic [7:0]  seg;
  } exp_t;

  logic clk_2 = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   pulses;
  int   seen;

  exp_t       sb[$];
  logic [7:0] m_cnt [NCHAN];
  int         m_presc;
  logic [3:0] m_tc;

  always #5 clk_2 = ~clk_2;

  contador_multicanal_if #(.NBITS(NBITS), .NCHAN(NCHAN)) bus ();

  contador_multicanal #(
    .NBITS(NBITS), .NCHAN(NCHAN), .PRESCALE(PRESCALE)
  ) dut (
    .clk_2(clk_2),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model arithmetic works on the decimal value in BCD builds.
  function automatic logic [7:0] m_inc(input logic [7:0] v);
`ifdef CONTADOR_BCD_EN
    int d;
    d = (int'(v[7:4]) * 10 + int'(v[3:0]) + 1) % 100;
    return {4'(d / 10), 4'(d % 10)};
`else
    return v + 8'd1;
`endif
  endfunction

  function automatic logic [7:0] m_dec(input logic [7:0] v);
`ifdef CONTADOR_BCD_EN
    int d;
    d = (int'(v[7:4]) * 10 + int'(v[3:0]) + 99) % 100;
    return {4'(d / 10), 4'(d % 10)};
`else
    return v - 8'd1;
`endif
  endfunction

  function automatic logic [7:0] m_clamp(input logic [7:0] v);
`ifdef CONTADOR_BCD_EN
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {hi, lo};
`else
    return v;
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCHAN; i++) m_cnt[i] = 8'h00;
    m_presc = 0;
    m_tc    = 4'h0;
  endtask

  task automatic model_edge();
    logic       tk;
    logic [3:0] ntc;
    int         s;
    tk  = bus.en && (m_presc == PRESCALE - 1);
    ntc = 4'h0;
    s   = int'(bus.chan_sel);
    if (bus.en) m_presc = tk ? 0 : m_presc + 1;
    if (s < NCHAN) begin
      case (bus.mode)
        2'b01: if (tk) begin
          if (m_cnt[s] == MAXV_E) begin
            ntc[s]   = 1'b1;
            m_cnt[s] = bus.wrap ? 8'h00 : MAXV_E;
          end else m_cnt[s] = m_inc(m_cnt[s]);
        end
        2'b10: if (tk) begin
          if (m_cnt[s] == 8'h00) begin
            ntc[s]   = 1'b1;
            m_cnt[s] = bus.wrap ? MAXV_E : 8'h00;
          end else m_cnt[s] = m_dec(m_cnt[s]);
        end
        2'b11:   m_cnt[s] = m_clamp(bus.load_val);
        default: ;
      endcase
    end
    m_tc = ntc;
  endtask

  function automatic exp_t m_expect();
    exp_t e;
    int   s;
    s = int'(bus.chan_sel);
    for (int i = 0; i < NCHAN; i++) e.all[i*8 +: 8] = m_cnt[i];
    e.tc  = m_tc;
    e.cnt = m_cnt[s];
    e.seg = {m_tc[s], SEG_TAB[m_cnt[s][3:0]]};
    return e;
  endfunction

  task automatic cycle(input string tag);
    exp_t e;
    model_edge();
    sb.push_back(m_expect());
    @(posedge clk_2);
    #1;
    e = sb.pop_front();
    chk({tag, ".count_all"}, bus.count_all, e.all);
    chk({tag, ".tc"}, 32'(bus.tc), 32'(e.tc));
    chk({tag, ".count"}, 32'(bus.count), 32'(e.cnt));
    chk({tag, ".SEG"}, 32'(bus.SEG), 32'(e.seg));
    chk({tag, ".LED"}, 32'(bus.LED), 32'(e.cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bus.en       = 1'b0;
    bus.chan_sel = '0;
    bus.mode     = 2'b00;
    bus.wrap     = 1'b0;
    bus.load_val = 8'h00;
    m_reset();

    // reset held, then released with en low
    repeat (3) begin
      @(posedge clk_2);
      #1;
      chk("rst.count_all", bus.count_all, 32'h0);
      chk("rst.tc", 32'(bus.tc), 32'h0);
      chk("rst.count", 32'(bus.count), 32'h0);
      chk("rst.SEG", 32'(bus.SEG), 32'h3F);
    end
    reset = 1'b1;
    repeat (2) cycle("idle");
    chk("idle.count_all", bus.count_all, 32'h0);

    // channel 1 counts up every second cycle
    bus.chan_sel = 2'd1;
    bus.mode     = 2'b01;
    bus.en       = 1'b1;
    bus.wrap     = 1'b1;
    repeat (10) cycle("up1");
    chk("up1.count5", 32'(bus.count), 32'd5);
    chk("up1.SEG5", 32'(bus.SEG), 32'h6D);
    chk("up1.others", bus.count_all, 32'h0000_0500);

    // channel 2 load near max then saturate
    bus.chan_sel = 2'd2;
    bus.mode     = 2'b11;
    bus.load_val = 8'hFE;
    cycle("ld2");
    chk("ld2.count", 32'(bus.count), 32'(LOAD_FE_E));
    bus.mode = 2'b01;
    bus.wrap = 1'b0;
    pulses   = 0;
    repeat (8) begin
      cycle("sat2");
      if (bus.tc[2]) begin
        pulses++;
        chk("sat2.dp", 32'(bus.SEG[7]), 32'd1);
      end
    end
    chk("sat2.count", 32'(bus.count), 32'(MAXV_E));
    chk("sat2.pulses", pulses, PULSES_E);

    // channel 0 down from zero with wrap
    bus.chan_sel = 2'd0;
    bus.mode     = 2'b10;
    bus.wrap     = 1'b1;
    cycle("dn0a");
    chk("dn0a.count", 32'(bus.count), 32'(MAXV_E));
    chk("dn0a.LED", 32'(bus.LED), 32'(MAXV_E));
    chk("dn0a.tc", 32'(bus.tc), 32'h1);
    cycle("dn0b");
    chk("dn0b.tc", 32'(bus.tc), 32'h0);
    chk("dn0b.count", 32'(bus.count), 32'(MAXV_E));

    // channel 3 up, then asynchronous reset between ticks
    bus.chan_sel = 2'd3;
    bus.mode     = 2'b01;
    repeat (4) cycle("up3");
    chk("up3.count", 32'(bus.count), 32'd2);
    reset = 1'b0;
    #1;
    chk("arst.count_all", bus.count_all, 32'h0);
    chk("arst.tc", 32'(bus.tc), 32'h0);
    chk("arst.SEG", 32'(bus.SEG), 32'h3F);
    @(posedge clk_2);
    #1;
    chk("arst.hold", bus.count_all, 32'h0);
    reset = 1'b1;
    m_reset();
    cycle("rel1");
    chk("rel1.count", 32'(bus.count), 32'h0);
    chk("rel1.tc", 32'(bus.tc), 32'h0);
    cycle("rel2");
    chk("rel2.count", 32'(bus.count), 32'd1);

    // wrap up from max, then load a value with a non-decimal digit
    bus.chan_sel = 2'd1;
    bus.mode     = 2'b11;
    bus.load_val = MAXV_E;
    cycle("ldmax");
    bus.mode = 2'b01;
    bus.wrap = 1'b1;
    seen     = 0;
    repeat (2) begin
      cycle("wrapup");
      if (bus.tc[1]) seen++;
    end
    chk("wrapup.count", 32'(bus.count), 32'h0);
    chk("wrapup.pulses", seen, 1);
    bus.mode     = 2'b11;
    bus.load_val = 8'h3C;
    cycle("ld3c");
`ifdef CONTADOR_BCD_EN
    chk("ld3c.count", 32'(bus.count), 32'h39);
    chk("ld3c.SEG", 32'(bus.SEG), 32'h6F);
`else
    chk("ld3c.count", 32'(bus.count), 32'h3C);
    chk("ld3c.SEG", 32'(bus.SEG), 32'h39);
`endif

    // hold mode, then en low freezes the prescaler and counting
    bus.mode = 2'b00;
    repeat (3) cycle("hold");
    bus.mode = 2'b01;
    bus.en   = 1'b0;
    repeat (3) cycle("frozen");
    chk("frozen.count", 32'(bus.count), 32'(m_clamp(8'h3C)));
    bus.en = 1'b1;
    repeat (3) cycle("resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
